inv_mixcolumns_seq: RTL
=======================

Name: inv_mixcolumns_seq

Overview:
Column-serial AES InvMixColumns stage for the AES-128 decryption datapath. It takes a 128-bit state through a valid/ready handshake and processes one 32-bit column per clock over 4 cycles. The result is a registered 128-bit state presented with valid/ready. It is the decrypt-side counterpart of the encryption MixColumns stage and sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop.

Parameters:
TEXT_WIDTH, 128, state width in bits; fixed at 128 and must equal the `TEXT_WIDTH define.
BYTE_WIDTH, 8, GF(2^8) element width; fixed at 8.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  state_i is valid
in_ready  output  1  block can accept a state this cycle (combinational)
state_i  input  128  input state; column c = bits [127-32c -: 32]; byte a0 is the MSB byte of the column
out_valid  output  1  state_o holds a completed result
out_ready  input  1  downstream accepts state_o
state_o  output  128  InvMixColumns result, same byte layout as state_i
busy  output  1  high in CALC

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; col counter = 0; work register = 0.
  - state_o = 0; out_valid = 0; busy = 0.
  - Reset asserted mid-CALC or in DONE aborts the operation and discards the result.
- FSM states: IDLE, CALC, DONE (encoded 2 bits; any unused encoding returns to IDLE).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready.
  - On the accept edge: state_i is captured into the work register, col = 0, next state = CALC.
- CALC, each edge:
  - Column col of the work register is replaced by its InvMixColumns result; col increments.
  - At the edge where col==3, state_o is loaded with the full result (columns 0..2 from work, column 3 freshly computed), out_valid is set, and next state = DONE.
- Latency: out_valid rises on the 4th rising edge after the accept edge.
- Per-column math, inputs a0..a3, all arithmetic in GF(2^8) with polynomial 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Multiplies are built from xtime chains: x2, x4, x8 and XORs. xtime = shift left 1, XOR 0x1B when the input MSB is 1. No lookup tables.
- DONE:
  - out_valid stays high and state_o stays stable until out_ready is high at a clock edge.
  - out_ready & !in_valid at the edge: out_valid cleared, next state = IDLE.
  - out_ready & in_valid at the edge: result handed off, new input captured, next state = CALC. Back-to-back throughput is one state per 5 cycles.
  - out_ready low: in_ready is low and new inputs are held off.
- in_valid during CALC is ignored; in_ready is low.
- state_i is sampled only on the accept edge. Changes to state_i afterwards do not affect the result.
- The work register is internal. state_o changes only on the completion edge or on reset.

Test Plan:
- Reset: drive rst_n low asynchronously, between edges → state_o=0, out_valid=0, in_ready=1 immediately, without waiting for a clock edge.
- Known vector: state_i=8e4da1bc_9fdc589d_01010101_c6c6c6c6 → after 4 edges state_o=db135345_f20a225c_01010101_c6c6c6c6, out_valid=1, busy was high for 4 cycles.
- Second vector: state_i=d5d5d7d6_4d7ebdf8_00000000_ffffffff → state_o=d4d4d4d5_2d26314c_00000000_ffffffff.
- Backpressure: hold out_ready=0 for 10 cycles after completion → out_valid and state_o stable, in_ready=0, in_valid pulses ignored. Then raise out_ready → handoff and return to IDLE.
- Back-to-back: keep in_valid=1 and out_ready=1 with two vectors → second accepted on the first vector's handoff edge, results 5 cycles apart, both correct.
- Mid-operation reset: assert rst_n low at the 2nd CALC cycle → all outputs cleared. A new vector after release produces the correct result with no residue from the aborted one.

Source files
------------

// File: rtl/inv_mixcolumns_seq.sv
// Column-serial AES InvMixColumns: one 32-bit column per clock, four clocks per state,
// with a valid/ready handshake on both sides and a registered result.
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif

module inv_mixcolumns_seq #(
   parameter int TEXT_WIDTH = `TEXT_WIDTH,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [TEXT_WIDTH-1:0] state_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [TEXT_WIDTH-1:0] state_o,
   output logic                  busy
);

   // state | meaning
   // IDLE  | waiting for an input state
   // CALC  | transforming column col of the work register, one per clock
   // DONE  | state_o valid, waiting for out_ready
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } fsm_t;

   fsm_t                  state_q;
   fsm_t                  state_d;
   logic [1:0]            col_q;
   logic [TEXT_WIDTH-1:0] work_q;
   logic [TEXT_WIDTH-1:0] work_next;
   logic [31:0]           col_in;
   logic [31:0]           col_res;
   logic                  accept;

   function automatic logic [BYTE_WIDTH-1:0] xtime(input logic [BYTE_WIDTH-1:0] b);
      return {b[BYTE_WIDTH-2:0], 1'b0} ^ (b[BYTE_WIDTH-1] ? 8'h1b : 8'h00);
   endfunction

   // 09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [BYTE_WIDTH-1:0] a  [4];
      logic [BYTE_WIDTH-1:0] m9 [4];
      logic [BYTE_WIDTH-1:0] mb [4];
      logic [BYTE_WIDTH-1:0] md [4];
      logic [BYTE_WIDTH-1:0] me [4];
      logic [BYTE_WIDTH-1:0] x2;
      logic [BYTE_WIDTH-1:0] x4;
      logic [BYTE_WIDTH-1:0] x8;
      a[0] = c[31:24];
      a[1] = c[23:16];
      a[2] = c[15:8];
      a[3] = c[7:0];
      for (int i = 0; i < 4; i++) begin
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   always_comb begin
      in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
      accept   = in_valid & in_ready;
      busy     = (state_q == CALC);
   end

   always_comb begin
      col_in = work_q[127:96];
      case (col_q)
         2'd0: col_in = work_q[127:96];
         2'd1: col_in = work_q[95:64];
         2'd2: col_in = work_q[63:32];
         2'd3: col_in = work_q[31:0];
         default: col_in = work_q[127:96];
      endcase
      col_res   = inv_col(col_in);
      work_next = work_q;
      case (col_q)
         2'd0: work_next[127:96] = col_res;
         2'd1: work_next[95:64]  = col_res;
         2'd2: work_next[63:32]  = col_res;
         2'd3: work_next[31:0]   = col_res;
         default: work_next = work_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = CALC;
         CALC: if (col_q == 2'd3) state_d = DONE;
         DONE: if (out_ready) state_d = in_valid ? CALC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q     <= 2'd0;
         work_q    <= '0;
         state_o   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            work_q <= state_i;
            col_q  <= 2'd0;
         end else if (state_q == CALC) begin
            work_q <= work_next;
            col_q  <= col_q + 2'd1;
            if (col_q == 2'd3) begin
               state_o   <= work_next;
               out_valid <= 1'b1;
            end
         end
         if ((state_q == DONE) && out_ready) out_valid <= 1'b0;
      end
   end

endmodule
